// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: STAGES chunks of WIDTH/STAGES bits, registered carry between chunks.
// Optional macro ADDER_SATURATE_EN clamps overflowing results to the signed limit in the output stage.
module pipelined_ripple_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] final_sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = WIDTH / STAGES;

    logic adv;
    logic ovf_reg;

    assign in_ready = ~out_valid | out_ready;
    assign adv      = in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Each word rotates right by CW per stage: the low chunk is consumed and its sum
            // re-enters at the top, so after STAGES stages the word is the full sum in order.
            logic             valid_reg;
            logic             carry_reg;
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] b_reg;

            logic             v_in;
            logic             c_in;
            logic [WIDTH-1:0] a_in;
            logic [WIDTH-1:0] b_in;
            logic [CW-1:0]    chunk;
            logic             c_next;
            logic [WIDTH-1:0] chunk_ext;
            logic [WIDTH-1:0] a_next;
            logic [WIDTH-1:0] b_next;
            logic [WIDTH-1:0] load_word;

            if (gi == 0) begin : g_src
                assign v_in = in_valid;
                assign a_in = input_a;
                assign b_in = mode ? ~input_b : input_b;
                assign c_in = carry_in ^ mode;
            end else begin : g_src
                assign v_in = g_stage[gi-1].valid_reg;
                assign a_in = g_stage[gi-1].a_reg;
                assign b_in = g_stage[gi-1].b_reg;
                assign c_in = g_stage[gi-1].carry_reg;
            end

            assign {c_next, chunk} = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]}
                                   + {{CW{1'b0}}, c_in};

            always_comb begin
                chunk_ext          = '0;
                chunk_ext[CW-1:0]  = chunk;
            end

            assign a_next = (a_in >> CW) | (chunk_ext << (WIDTH - CW));
            assign b_next = (b_in >> CW) | (b_in << (WIDTH - CW));

            if (gi == STAGES - 1) begin : g_tail
                // The last chunk's top bits are the original operand MSBs.
                logic ovf_next;
                assign ovf_next = (a_in[CW-1] == b_in[CW-1]) & (chunk[CW-1] != a_in[CW-1]);
`ifdef ADDER_SATURATE_EN
                assign load_word = ovf_next ? {a_in[CW-1], {(WIDTH-1){~a_in[CW-1]}}} : a_next;
`else
                assign load_word = a_next;
`endif
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        ovf_reg <= 1'b0;
                    end else if (adv && v_in) begin
                        ovf_reg <= ovf_next;
                    end
                end
            end else begin : g_tail
                assign load_word = a_next;
            end

            // Data only loads with a valid slot, so bubbles leave the last result in place.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    a_reg     <= '0;
                    b_reg     <= '0;
                end else if (adv) begin
                    valid_reg <= v_in;
                    if (v_in) begin
                        carry_reg <= c_next;
                        a_reg     <= load_word;
                        b_reg     <= b_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign final_sum = g_stage[STAGES-1].a_reg;
    assign carry_out = g_stage[STAGES-1].carry_reg;
    assign overflow  = ovf_reg;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: directed cases, random streams with back-pressure,
// and mid-stream reset, checked against an arithmetic reference model.
module tb_pipelined_ripple_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         carry_in;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] final_sum;
    logic         carry_out;
    logic         overflow;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_a   (input_a),
        .input_b   (input_b),
        .carry_in  (carry_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .final_sum (final_sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         md;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    bit   mon_en = 1'b0;
    bit   lat_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum for result/carry, signed integer sum for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic md);
        exp_t         e;
        logic [W-1:0] be;
        longint       c;
        longint       full;
        longint       r;
        longint       smax;
        longint       smin;
        be   = md ? ~b : b;
        c    = longint'(cin ^ md);
        full = longint'(a) + longint'(be) + c;
        r    = longint'($signed(a)) + longint'($signed(be)) + c;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -smax - 1;
        e.a    = a;
        e.b    = b;
        e.cin  = cin;
        e.md   = md;
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (r > smax) || (r < smin);
`ifdef ADDER_SATURATE_EN
        if (e.ovf) e.sum = (r > smax) ? smax[W-1:0] : smin[W-1:0];
`endif
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records input transfers, checks output transfers and stall stability.
    initial begin : monitor
        logic         held;
        logic [W-1:0] h_sum;
        logic         h_c;
        logic         h_o;
        exp_t         e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_en) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", final_sum, h_sum);
                    check("hold_cout", carry_out, h_c);
                    check("hold_ovf", overflow, h_o);
                end
                if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                if (in_valid && in_ready) begin
                    e = model(input_a, input_b, carry_in, mode);
                    e.cyc = cyc;
                    sb.push_back(e);
                    n_in++;
                end
                if (out_valid && out_ready) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("sum", final_sum, e.sum);
                        check("cout", carry_out, e.cout);
                        check("ovf", overflow, e.ovf);
                        if (lat_en) check("latency", cyc - e.cyc, S);
                        $display("txn %0d a=%h b=%h cin=%0d mode=%0d -> sum=%h cout=%0d ovf=%0d",
                                 n_out, e.a, e.b, e.cin, e.md, final_sum, carry_out, overflow);
                        n_out++;
                    end
                end
                held  = out_valid && !out_ready;
                h_sum = final_sum;
                h_c   = carry_out;
                h_o   = overflow;
            end
        end
    end

    task automatic send_dir(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic md, input logic [W-1:0] esum,
                            input logic ec, input logic eo);
        int lat;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        input_a  = a;
        input_b  = b;
        carry_in = cin;
        mode     = md;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        input_a  = W'($urandom);
        input_b  = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        check({tag, "_lat"}, lat, S);
        check({tag, "_sum"}, final_sum, esum);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        $display("txn %s a=%h b=%h cin=%0d mode=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
                 tag, a, b, cin, md, final_sum, carry_out, overflow, lat);
    endtask

    task automatic drain(input string tag);
        int k;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int in0;
        int out0;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        input_a   = 32'hDEAD_BEEF;
        input_b   = 32'h1234_5678;
        carry_in  = 1'b1;
        mode      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", final_sum, 0);
        check("rst_cout", carry_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed cases
        send_dir("add5_3", 32'h5, 32'h3, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0);
        send_dir("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
`ifdef ADDER_SATURATE_EN
        send_dir("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_dir("negovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        send_dir("posovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_dir("negovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        send_dir("sub5_7", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_dir("sub7_5b", 32'h7, 32'h5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
        drain("dir");

        // Back-to-back random ops at full throughput, latency checked
        mon_en = 1'b1;
        lat_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            input_a  = rand_word();
            input_b  = rand_word();
            carry_in = 1'($urandom);
            mode     = 1'($urandom);
        end
        drain("b2b");
        lat_en = 1'b0;

        // Random back-pressure
        in0  = n_in;
        out0 = n_out;
        k    = 0;
        while (n_in - in0 < 40 && k < 2000) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            input_a   = rand_word();
            input_b   = rand_word();
            carry_in  = 1'($urandom);
            mode      = 1'($urandom);
            k++;
        end
        check("bp_enough_ops", (n_in - in0) >= 40, 1);
        drain("bp");
        check("bp_count", n_out - out0, n_in - in0);

        // Fill the pipeline under stall, then release: in and out transfer together
        for (int i = 0; i < S + 3; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            input_a   = rand_word();
            input_b   = rand_word();
            carry_in  = 1'($urandom);
            mode      = 1'($urandom);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        input_a   = rand_word();
        @(negedge clk);
        check("simul_xfer", in_valid & in_ready & out_valid & out_ready, 1);
        drain("full");

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            input_a  = W'($urandom) | 32'h1;
            input_b  = W'($urandom);
            carry_in = 1'b0;
            mode     = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", final_sum, 0);
        check("mid_rst_cout", carry_out, 0);
        check("mid_rst_ovf", overflow, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end

        mon_en = 1'b0;
        send_dir("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        drain("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple chunks, with a registered carry between chunks, so a 64-bit or wider datapath can close timing.
- Sits between producer and consumer datapath blocks behind a valid/ready handshake.
- Accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be at least 2.
- STAGES, 4, number of pipeline stages; WIDTH must be divisible by STAGES; chunk width CW = WIDTH/STAGES; STAGES=1 gives a single registered ripple adder.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on input_a/input_b/carry_in/mode are valid.
- in_ready  output  1  block accepts an operation this cycle.
- input_a  input  WIDTH  operand A.
- input_b  input  WIDTH  operand B.
- carry_in  input  1  carry in for add; borrow in for subtract.
- mode  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result.
- final_sum  output  WIDTH  result.
- carry_out  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- overflow  output  1  signed (two's complement) overflow of the operation.

Behaviour:
- Clock and reset: one clock domain.
- While rst_n=0, all pipeline valid bits clear asynchronously and all datapath registers clear to 0. Reset values: out_valid=0, final_sum=0, carry_out=0, overflow=0.
- in_ready is combinational and does not depend on rst_n: in_ready = ~out_valid | out_ready.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Operand preparation:
  - b_eff = mode ? ~input_b : input_b.
  - c_eff = carry_in ^ mode.
  - So subtract with carry_in=0 gives A-B, and subtract with carry_in=1 gives A-B-1.
- Pipeline advance:
  - Global enable adv = in_ready. When adv=0, every stage register holds (full stall; no bubble collapsing).
  - Each stage k (k=0..STAGES-1) computes chunk k, bits [k*CW +: CW], as a ripple sum of skewed A chunk + skewed b_eff chunk + the registered carry from stage k-1. Stage 0 uses c_eff.
  - Unconsumed higher chunks are carried forward in skew registers.
  - Completed lower sum chunks are carried forward in deskew registers, so every chunk of one operation emerges in the same cycle.
- Latency: exactly STAGES cycles from input transfer to out_valid, with out_ready held at 1. Throughput: 1 op per cycle.
- A valid bit travels with each stage. Bubbles (in_valid=0 while adv=1) propagate as invalid slots.
- Output stage:
  - carry_out = carry from the final chunk.
  - overflow = (a_msb == b_eff_msb) & (sum_msb != a_msb), using registered copies of the MSBs.
  - Outputs are registered, and they hold stable while out_valid & ~out_ready.
- Boundary conditions:
  - Full pipeline with out_ready=0: in_ready=0; inputs are ignored even if in_valid=1; no data is lost or duplicated.
  - out_ready rising while the pipeline is full: the output transfer and a new input transfer occur in the same cycle.
  - Wrap-around: the sum is modulo 2^WIDTH, and the carry is reported on carry_out.
  - Reset asserted mid-operation: all in-flight operations are discarded; no result appears after rst_n deasserts until a new input transfer plus STAGES cycles.
  - Changes to input_a, input_b, mode or carry_in while no transfer occurs have no effect.

Optional Feature:
- Macro: ADDER_SATURATE_EN.
- With the macro defined:
  - When overflow=1, final_sum is clamped to the signed limit. A positive operand sign gives 0111…1; a negative operand sign gives 1000…0. The sign is taken from a_msb.
  - carry_out and overflow are unchanged.
  - The clamp is applied in the output register stage, so latency is unchanged.
- Without the macro: final_sum is the raw wrapped result and no clamp logic is synthesised.

Test Plan:
- Reset and latency: WIDTH=32, STAGES=4; release rst_n, then one op A=0x0000_0005, B=0x0000_0003, add, cin=0, out_ready=1 -> out_valid high exactly 4 cycles later with final_sum=0x0000_0008, carry_out=0, overflow=0. All outputs read 0 during reset.
- Cross-chunk carry ripple: A=0xFFFF_FFFF, B=0x0000_0001, add, cin=0 -> final_sum=0x0000_0000, carry_out=1, overflow=0. Then A=0x7FFF_FFFF, B=1 -> final_sum=0x8000_0000, overflow=1; with ADDER_SATURATE_EN defined, final_sum=0x7FFF_FFFF.
- Subtract and borrow: A=5, B=7, mode=1, cin=0 -> final_sum=0xFFFF_FFFE, carry_out=0. Then A=7, B=5, mode=1, cin=1 -> final_sum=1, carry_out=1.
- Back-pressure: stream 10 random ops with out_ready toggling randomly -> results match a reference model in order, none dropped or duplicated. While out_valid=1 and out_ready=0, in_ready=0 and the outputs stay stable.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately. After release with in_valid=0 for 10 cycles, out_valid remains 0.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=64/STAGES=8 and WIDTH=16/STAGES=16, each with 1000 random back-to-back ops -> results are bit-exact to (A + b_eff + c_eff) mod 2^WIDTH, and latency equals STAGES.
